display_scanner: RTL and testbench

Time-multiplexed scan controller for the board's four-digit seven-segment display. It shares one `hex_to_sevenseg` decoder across `NUM_DIGITS` digit sources and drives the active-low digit selects plus the shared segment bus. It sits between the design core (Turing-machine state, tape values) and the `display_sel`/`display` board pins, replacing the hard-wired single-digit select. Values are double-buffered and committed only at frame boundaries, so the displayed frame never tears.

---
 rtl/display_pkg.sv | 21 ++
 rtl/hex_to_sevenseg.sv | 38 +++
 rtl/display_scanner.sv | 144 ++++++++++++++
 tb/tb_display_scanner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ============================================================================
//  display_pkg
//  Shared types and constants for the multiplexed seven-segment scanner.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF              = 8'hFF;
    localparam int         DEFAULT_DIGIT_CYCLES = 50000;
    localparam int         DEFAULT_BLANK_CYCLES = 16;

endpackage : display_pkg

`default_nettype wire

// File: rtl/hex_to_sevenseg.sv
// ============================================================================
//  hex_to_sevenseg
//  Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hex_to_sevenseg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule : hex_to_sevenseg

`default_nettype wire

// File: rtl/display_scanner.sv
// ============================================================================
//  display_scanner
//  Time-multiplexed, frame-synchronously double-buffered seven-segment scanner.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = DEFAULT_DIGIT_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    update_req,
    output logic                    update_ack,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   display_sel,
    output logic [7:0]              display
);

    localparam int                SLOT_W     = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int                IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // slot_q/idx_q name the position whose outputs are registered on the next
    // edge; state_q is the phase of the position currently being shown.
    scan_state_t               state_q, state_d;
    logic [SLOT_W-1:0]         slot_q, slot_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   shadow_digits_q;
    logic [NUM_DIGITS-1:0]     shadow_dp_q;
    logic [NUM_DIGITS-1:0]     shadow_en_q;
    logic [NUM_DIGITS-1:0]     sel_q, sel_d;
    logic [7:0]                display_q, display_d;
    logic                      ack_q, ack_d;
    logic                      fs_q, fs_d;

    logic                      w_boundary;
    logic                      w_commit;
    logic [3:0]                w_digit;
    logic                      w_dp;
    logic                      w_en;
    logic [6:0]                w_seg;

    // Leaving a DRIVE cycle into digit 0, slot 0 is the frame boundary; the
    // state_q test excludes the very first edge after reset.
    assign w_boundary = (state_q == DRIVE) && (slot_q == '0) && (idx_q == '0);
    assign w_commit   = w_boundary && update_req;

    always_comb begin
        slot_d = slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        w_digit = 4'h0;
        w_dp    = 1'b0;
        w_en    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_digit = shadow_digits_q[4*i +: 4];
                w_dp    = shadow_dp_q[i];
                w_en    = shadow_en_q[i];
            end
        end
    end

    hex_to_sevenseg u_hex_to_sevenseg (
        .hex_i (w_digit),
        .seg_o (w_seg)
    );

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = (slot_q < SLOT_BLANK) ? BLANK : DRIVE;
    end

    // FSM: outputs
    always_comb begin
        sel_d     = '1;
        display_d = SEG_OFF;
        if ((state_d == DRIVE) && w_en) begin
            sel_d     = ~(NUM_DIGITS'(1) << idx_q);
            display_d = {~w_dp, w_seg};
        end
        ack_d = w_commit;
        fs_d  = w_boundary;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q          <= '0;
            idx_q           <= '0;
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            shadow_en_q     <= '0;
            sel_q           <= '1;
            display_q       <= SEG_OFF;
            ack_q           <= 1'b0;
            fs_q            <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            display_q <= display_d;
            ack_q     <= ack_d;
            fs_q      <= fs_d;
            if (w_commit) begin
                shadow_digits_q <= digits_in;
                shadow_dp_q     <= dp_in;
                shadow_en_q     <= en_in;
            end
        end
    end

    assign display_sel = sel_q;
    assign display     = display_q;
    assign update_ack  = ack_q;
    assign frame_start = fs_q;

endmodule : display_scanner

`default_nettype wire

// File: tb/tb_display_scanner.sv
// ============================================================================
//  tb_display_scanner
//  Directed stimulus with a frame-level reference model of the scanner.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_scanner;

    localparam int ND    = 4;
    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * DC;

    logic            clock;
    logic            reset;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0]   dp_in;
    logic [ND-1:0]   en_in;
    logic            update_req;
    logic            update_ack;
    logic            frame_start;
    logic [ND-1:0]   display_sel;
    logic [7:0]      display;

    display_scanner #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .update_req  (update_req),
        .update_ack  (update_ack),
        .frame_start (frame_start),
        .display_sel (display_sel),
        .display     (display)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference segment table, active low {g,f,e,d,c,b,a}
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_pass;
    int n_total;
    int cyc;

    logic [4*ND-1:0] m_dig;
    logic [ND-1:0]   m_dp;
    logic [ND-1:0]   m_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc - 1, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock of the model: cycle cyc is the value registered on edge cyc.
    task automatic step();
        int pos, dg, off;
        logic boundary;
        logic e_ack;
        logic [ND-1:0] e_sel;
        logic [7:0] e_disp;
        @(posedge clock);
        pos      = cyc % FRAME;
        dg       = pos / DC;
        off      = pos % DC;
        boundary = (cyc != 0) && (pos == 0);
        e_ack    = boundary && update_req;
        if (e_ack) begin
            m_dig = digits_in;
            m_dp  = dp_in;
            m_en  = en_in;
        end
        e_sel  = '1;
        e_disp = 8'hFF;
        if (off >= BC && m_en[dg]) begin
            e_sel[dg] = 1'b0;
            e_disp    = {~m_dp[dg], seg_tab[m_dig[4*dg +: 4]]};
        end
        @(negedge clock);
        cyc++;
        chk("display_sel", 32'(display_sel), 32'(e_sel));
        chk("display", 32'(display), 32'(e_disp));
        chk("update_ack", 32'(update_ack), 32'(e_ack));
        chk("frame_start", 32'(frame_start), 32'(boundary));
    endtask

    task automatic run_to(input int last);
        while (cyc <= last) step();
    endtask

    task automatic clear_model();
        m_dig = '0;
        m_dp  = '0;
        m_en  = '0;
        cyc   = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        repeat (2) @(negedge clock);
        chk("reset_sel", 32'(display_sel), 32'hF);
        chk("reset_display", 32'(display), 32'hFF);
        chk("reset_ack", 32'(update_ack), 32'h0);
        chk("reset_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset      = 1'b1;
        digits_in  = '0;
        dp_in      = '0;
        en_in      = '0;
        update_req = 1'b0;
        clear_model();

        // Idle: dark for three frames, frame_start every 32 cycles
        do_reset();
        run_to(0);
        chk("lit_c0_fs", 32'(frame_start), 32'h0);
        run_to(32);
        chk("lit_c32_fs", 32'(frame_start), 32'h1);
        run_to(100);

        // First commit of 1234, all enabled
        do_reset();
        digits_in  = 16'h1234;
        en_in      = 4'hF;
        dp_in      = 4'h0;
        update_req = 1'b1;
        run_to(32);
        chk("lit_ack32", 32'(update_ack), 32'h1);
        update_req = 1'b0;
        run_to(34);
        chk("lit_s0_sel", 32'(display_sel), 32'hE);
        chk("lit_s0_disp", 32'(display), 32'h99);
        run_to(42);
        chk("lit_s1_disp", 32'(display), 32'hB0);
        run_to(50);
        chk("lit_s2_disp", 32'(display), 32'hA4);
        run_to(58);
        chk("lit_s3_sel", 32'(display_sel), 32'h7);
        chk("lit_s3_disp", 32'(display), 32'hF9);
        run_to(63);

        // Decimal point on digit 1
        dp_in      = 4'b0010;
        update_req = 1'b1;
        run_to(64);
        update_req = 1'b0;
        run_to(74);
        chk("lit_dp1_disp", 32'(display), 32'h30);
        run_to(95);

        // Only digits 0 and 2 enabled
        en_in      = 4'b0101;
        update_req = 1'b1;
        run_to(96);
        update_req = 1'b0;
        run_to(107);
        chk("lit_en_dark_sel", 32'(display_sel), 32'hF);
        run_to(137);

        // Request withdrawn before the boundary: nothing captured
        digits_in  = 16'h5678;
        en_in      = 4'hF;
        update_req = 1'b1;
        run_to(148);
        update_req = 1'b0;
        run_to(162);
        chk("lit_noack_sel", 32'(display_sel), 32'hE);
        chk("lit_noack_disp", 32'(display), 32'h99);
        run_to(170);

        // Held request: one ack per frame
        update_req = 1'b1;
        run_to(192);
        chk("lit_ack192", 32'(update_ack), 32'h1);
        run_to(224);
        chk("lit_ack224", 32'(update_ack), 32'h1);
        update_req = 1'b0;
        run_to(226);
        chk("lit_5678_disp", 32'(display), 32'h80);
        run_to(270);

        // Asynchronous reset in the third DRIVE cycle of digit 2, request pending
        update_req = 1'b1;
        run_to(276);
        chk("lit_pre_rst_sel", 32'(display_sel), 32'hB);
        chk("lit_pre_rst_disp", 32'(display), 32'h82);
        #1;
        reset = 1'b1;
        clear_model();
        #1;
        chk("async_rst_sel", 32'(display_sel), 32'hF);
        chk("async_rst_disp", 32'(display), 32'hFF);
        chk("async_rst_ack", 32'(update_ack), 32'h0);
        update_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_to(70);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_display_scanner

`default_nettype wire
